// File: rtl/sevenseg_pkg.sv
// Shared seven-segment encoding: blank pattern, hex glyph table and lookup.
// Pure constants and a combinational function, no latency.
// No flow control; consumers index the table directly.
package sevenseg_pkg;

   // Active-low segment order abc_defg: bit 6 = a ... bit 0 = g.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b0000001,   // 0
      7'b1001111,   // 1
      7'b0010010,   // 2
      7'b0000110,   // 3
      7'b1001100,   // 4
      7'b0100100,   // 5
      7'b0100000,   // 6
      7'b0001111,   // 7
      7'b0000000,   // 8
      7'b0001100,   // 9
      7'b0001000,   // A
      7'b1100000,   // b
      7'b0110001,   // C
      7'b1000010,   // d
      7'b0110000,   // E
      7'b0111000    // F
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/sevenseg_lzb.sv
// Leading-zero blanking mask: flags digits whose nibble and all higher nibbles are zero.
// Purely combinational, zero latency.
// No flow control; digit 0 is never flagged so a value of zero still shows "0".
module sevenseg_lzb #(
   parameter int N_DIGITS = 4
) (
   input  logic [4*N_DIGITS-1:0] nibbles,
   input  logic                  enable,
   output logic [N_DIGITS-1:0]   blank
);

   logic zero_run;

   // Walk from the most significant digit down, tracking whether everything so far is zero.
   always_comb begin
      zero_run = 1'b1;
      blank    = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (nibbles[4*k +: 4] == 4'h0);
         blank[k] = enable & zero_run & (k != 0);
      end
   end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-synchronous capture.
// All outputs registered: one cycle from internal state / live inputs to pins.
// No backpressure; free-running scan, inputs only sampled at the frame boundary tick.
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [4*N_DIGITS-1:0] i_data,
   input  logic [N_DIGITS-1:0]   i_dp,
   input  logic                  i_blank_lz,
   input  logic                  i_enable,
   output logic [6:0]            o_segments,
   output logic                  o_dp,
   output logic [N_DIGITS-1:0]   o_anodes,
   output logic                  o_frame
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic [4*N_DIGITS-1:0] sh_data;
   logic [N_DIGITS-1:0]   sh_dp;

   logic                  tick;
   logic                  frame_end;
   logic [N_DIGITS-1:0]   blank;
   logic [N_DIGITS-1:0]   anodes_nxt;
   logic [3:0]            nibble;
   logic                  dp_sel;
   logic                  blank_sel;

   assign tick      = (cnt == CNT_LAST);
   assign frame_end = tick && (idx == IDX_LAST);

   // Blanking looks at the captured frame, but the enable is taken live.
   sevenseg_lzb #(
      .N_DIGITS (N_DIGITS)
   ) u_lzb (
      .nibbles (sh_data),
      .enable  (i_blank_lz),
      .blank   (blank)
   );

   // Prescaler: holds each digit for REFRESH_DIV cycles.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   // Digit index: steps once per slot and wraps after the last digit.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         idx <= '0;
      else if (tick)
         idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
   end

   // Shadow copy of the display data, refreshed only at the frame boundary to avoid tearing.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sh_data <= '0;
         sh_dp   <= '0;
      end else if (frame_end) begin
         sh_data <= i_data;
         sh_dp   <= i_dp;
      end
   end

   // Select the current digit's glyph inputs and build the one-cold anode pattern.
   always_comb begin
      nibble     = 4'h0;
      dp_sel     = 1'b0;
      blank_sel  = 1'b0;
      anodes_nxt = '1;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            nibble        = sh_data[4*k +: 4];
            dp_sel        = sh_dp[k];
            blank_sel     = blank[k];
            anodes_nxt[k] = 1'b0;
         end
      end
      // First cycle of every slot is dead time so the previous digit cannot ghost.
      if ((cnt == '0) || !i_enable)
         anodes_nxt = '1;
   end

   // Output registers: everything seen at the pins is one cycle behind the scan state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_anodes   <= '1;
         o_segments <= SEG_BLANK;
         o_dp       <= 1'b1;
         o_frame    <= 1'b0;
      end else begin
         o_anodes   <= anodes_nxt;
         o_segments <= blank_sel ? SEG_BLANK : hex_to_seg(nibble);
         o_dp       <= ~dp_sel;
         o_frame    <= frame_end;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: directed scenarios plus randomized traffic against a cycle-indexed model.
// Model derives display state from elapsed cycles since reset and recorded input history.
// A second single-digit instance covers the degenerate one-digit scan.
`timescale 1ns/1ps
module tb_sevenseg_scan;

   localparam int N  = 4;
   localparam int R  = 4;
   localparam int F  = N * R;
   localparam int HN = 4096;

   logic           clk  = 1'b0;
   logic           rst  = 1'b1;
   logic [4*N-1:0] data = '0;
   logic [N-1:0]   dp   = '0;
   logic           blz  = 1'b0;
   logic           en   = 1'b1;
   logic [6:0]     seg;
   logic           odp;
   logic [N-1:0]   an;
   logic           frm;

   logic [3:0]     data1 = '0;
   logic           dp1   = 1'b0;
   logic [6:0]     seg1;
   logic           odp1;
   logic           an1;
   logic           frm1;

   logic [N+8:0]   obs;
   logic [9:0]     obs1;
   assign obs  = {an, seg, odp, frm};
   assign obs1 = {an1, seg1, odp1, frm1};

   int total = 0;
   int bad   = 0;
   int p     = 0;

   logic [4*N-1:0] h_data [HN];
   logic [N-1:0]   h_dp   [HN];
   logic           h_blz  [HN];
   logic           h_en   [HN];
   logic [3:0]     h_d1   [HN];
   logic           h_p1   [HN];

   sevenseg_scan #(.N_DIGITS(N), .REFRESH_DIV(R)) dut (
      .i_clk(clk), .i_reset(rst), .i_data(data), .i_dp(dp),
      .i_blank_lz(blz), .i_enable(en),
      .o_segments(seg), .o_dp(odp), .o_anodes(an), .o_frame(frm)
   );

   sevenseg_scan #(.N_DIGITS(1), .REFRESH_DIV(2)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_data(data1), .i_dp(dp1),
      .i_blank_lz(blz), .i_enable(en),
      .o_segments(seg1), .o_dp(odp1), .o_anodes(an1), .o_frame(frm1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, wanted finish");
      $fatal(1);
   end

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0001100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   // Expected pins after the edge closing cycle q (q counted from reset release).
   function automatic logic [N+8:0] model(input int q);
      int             d;
      int             c;
      logic [4*N-1:0] sd;
      logic [N-1:0]   sdp;
      logic [N-1:0]   ea;
      logic [6:0]     es;
      logic           lz;
      d = (q / R) % N;
      if (q < F) begin
         sd  = '0;
         sdp = '0;
      end else begin
         c   = (q / F) * F - 1;
         sd  = h_data[c % HN];
         sdp = h_dp[c % HN];
      end
      lz = h_blz[q % HN] && (d != 0) && ((sd >> (4 * d)) == '0);
      es = lz ? 7'b1111111 : ref_seg(sd[4*d +: 4]);
      ea = (((q % R) == 0) || !h_en[q % HN]) ? '1 : ~(N'(1) << d);
      return {ea, es, ~sdp[d], ((q % F) == F - 1)};
   endfunction

   function automatic logic [9:0] model1(input int q);
      logic [3:0] sd;
      logic       sdp;
      int         c;
      if (q < 2) begin
         sd  = '0;
         sdp = 1'b0;
      end else begin
         c   = (q / 2) * 2 - 1;
         sd  = h_d1[c % HN];
         sdp = h_p1[c % HN];
      end
      return {(((q % 2) == 0) || !h_en[q % HN]), ref_seg(sd), ~sdp, ((q % 2) == 1)};
   endfunction

   task automatic step(output logic [N+8:0] e);
      h_data[p % HN] = data;
      h_dp[p % HN]   = dp;
      h_blz[p % HN]  = blz;
      h_en[p % HN]   = en;
      h_d1[p % HN]   = data1;
      h_p1[p % HN]   = dp1;
      @(posedge clk);
      #1;
      e = model(p);
      p++;
   endtask

   task automatic wait_frame(output bit ok);
      logic [N+8:0] e;
      ok = 1'b0;
      for (int i = 0; i < 2 * F && !ok; i++) begin
         step(e);
         ok = frm;
      end
   endtask

   task automatic test_reset();
      logic [N+8:0] e;
      data = 16'h12AF; dp = 4'b0100; blz = 1'b0; en = 1'b1; rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (obs !== {4'hF, 7'b1111111, 1'b1, 1'b0}) begin
         bad++; $display("FAIL reset_values: got %b want %b", obs, {4'hF, 7'b1111111, 1'b1, 1'b0});
      end
      rst = 1'b0;
      p   = 0;
      step(e);
      total++;
      if (an !== 4'hF) begin bad++; $display("FAIL dead_cycle: got %b want 1111", an); end
      step(e);
      total++;
      if ({an, seg} !== {4'b1110, 7'b0000001}) begin
         bad++; $display("FAIL first_lit: got %b want 11100000001", {an, seg});
      end
      for (int i = 0; i < F - 2; i++) begin
         step(e);
         total++;
         if (obs !== e) begin bad++; $display("FAIL reset_scan: got %b want %b", obs, e); end
      end
   endtask

   task automatic test_pattern();
      logic [N+8:0] e;
      logic [6:0]   ws;
      logic         wd;
      logic [N-1:0] seen;
      bit           ok;
      wait_frame(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL pattern_frame: got no pulse want pulse"); end
      seen = '0;
      for (int i = 0; i < F; i++) begin
         step(e);
         total++;
         if (obs !== e) begin bad++; $display("FAIL pattern_model: got %b want %b", obs, e); end
         if (an != 4'hF) begin
            case (an)
               4'b1110: begin ws = 7'b0111000; wd = 1'b1; seen[0] = 1'b1; end
               4'b1101: begin ws = 7'b0001000; wd = 1'b1; seen[1] = 1'b1; end
               4'b1011: begin ws = 7'b0010010; wd = 1'b0; seen[2] = 1'b1; end
               default: begin ws = 7'b1001111; wd = 1'b1; seen[3] = 1'b1; end
            endcase
            total++;
            if ({seg, odp} !== {ws, wd}) begin
               bad++; $display("FAIL pattern_glyph: anodes %b got %b want %b", an, {seg, odp}, {ws, wd});
            end
         end
      end
      total++;
      if (seen !== 4'hF) begin bad++; $display("FAIL pattern_slots: got %b want 1111", seen); end
   endtask

   task automatic test_blank();
      logic [N+8:0] e;
      logic [6:0]   ws;
      bit           ok;
      data = 16'h0070; blz = 1'b1;
      wait_frame(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL blank_frame: got no pulse want pulse"); end
      for (int i = 0; i < F; i++) begin
         step(e);
         total++;
         if (obs !== e) begin bad++; $display("FAIL blank_model: got %b want %b", obs, e); end
         if (an != 4'hF) begin
            case (an)
               4'b1110: ws = 7'b0000001;
               4'b1101: ws = 7'b0001111;
               default: ws = 7'b1111111;
            endcase
            total++;
            if (seg !== ws) begin bad++; $display("FAIL blank_0070: anodes %b got %b want %b", an, seg, ws); end
         end
      end
      data = 16'h0000;
      wait_frame(ok);
      for (int i = 0; i < F; i++) begin
         step(e);
         if (an != 4'hF) begin
            ws = (an == 4'b1110) ? 7'b0000001 : 7'b1111111;
            total++;
            if ({seg, odp} !== {ws, an != 4'b1011}) begin
               bad++; $display("FAIL blank_zero: anodes %b got %b want %b", an, {seg, odp}, {ws, an != 4'b1011});
            end
         end
      end
   endtask

   task automatic test_midframe();
      logic [N+8:0] e;
      bit           ok;
      bit           found;
      int           n;
      data = 16'h3456; blz = 1'b0;
      wait_frame(ok);
      wait_frame(ok);
      n = 0;
      found = 1'b0;
      for (int i = 0; i < 2 * F && !found; i++) begin
         if (i == 5) data = 16'h789A;
         step(e);
         n++;
         total++;
         if (obs !== e) begin bad++; $display("FAIL mid_model: got %b want %b", obs, e); end
         if (an == 4'b1110) begin
            total++;
            if (seg !== 7'b0100000) begin bad++; $display("FAIL mid_old_held: got %b want 0100000", seg); end
         end
         found = frm;
      end
      total++;
      if (n !== F) begin bad++; $display("FAIL frame_period: got %0d want %0d", n, F); end
      for (int i = 0; i < F; i++) begin
         step(e);
         if (an == 4'b1110) begin
            total++;
            if (seg !== 7'b0001000) begin bad++; $display("FAIL mid_new_shown: got %b want 0001000", seg); end
         end
      end
   endtask

   task automatic test_enable();
      logic [N+8:0] e;
      int           pulses;
      en = 1'b0;
      pulses = 0;
      for (int i = 0; i < 2 * F; i++) begin
         step(e);
         total++;
         if (an !== 4'hF) begin bad++; $display("FAIL enable_off: got %b want 1111", an); end
         if (frm) pulses++;
      end
      total++;
      if (pulses !== 2) begin bad++; $display("FAIL enable_frames: got %0d want 2", pulses); end
      en = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [N+8:0] e;
      bit           found;
      int           n;
      data = 16'hBEEF; dp = 4'b1001;
      found = 1'b0;
      for (int i = 0; i < 2 * F && !found; i++) begin
         step(e);
         found = (an == 4'b1011);
      end
      total++;
      if (!found) begin bad++; $display("FAIL midreset_find: got no idx2 slot want idx2 slot"); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (obs !== {4'hF, 7'b1111111, 1'b1, 1'b0}) begin
         bad++; $display("FAIL midreset_values: got %b want %b", obs, {4'hF, 7'b1111111, 1'b1, 1'b0});
      end
      rst = 1'b0;
      p   = 0;
      n   = 0;
      found = 1'b0;
      for (int i = 0; i < 2 * F && !found; i++) begin
         step(e);
         n++;
         total++;
         if (obs !== e) begin bad++; $display("FAIL midreset_model: got %b want %b", obs, e); end
         found = frm;
      end
      total++;
      if (n !== F) begin bad++; $display("FAIL midreset_capture: got %0d want %0d", n, F); end
   endtask

   task automatic test_random();
      logic [N+8:0] e;
      logic [9:0]   e1;
      for (int i = 0; i < 30 * F; i++) begin
         if ($urandom_range(3) == 0) begin
            data = 16'($urandom);
            dp   = 4'($urandom);
         end
         if ($urandom_range(7) == 0) data = data & 16'h00FF;
         if ($urandom_range(7) == 0) blz = ~blz;
         if ($urandom_range(15) == 0) en = ~en;
         data1 = 4'($urandom);
         dp1   = 1'($urandom);
         step(e);
         e1 = model1(p - 1);
         total++;
         if (obs !== e) begin bad++; $display("FAIL random_scan: cycle %0d got %b want %b", p - 1, obs, e); end
         total++;
         if (obs1 !== e1) begin bad++; $display("FAIL single_digit: cycle %0d got %b want %b", p - 1, obs1, e1); end
      end
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_blank();
      test_midframe();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It accepts a packed vector of hex nibbles plus per-digit decimal points and scans one digit at a time at a programmable refresh rate. It also provides frame-synchronous data capture (no tearing), optional leading-zero blanking and a one-cycle anode dead time between digits. It sits between the PS/2 keyboard data path and the board display pins, replacing per-digit static decoders.

## Interface
- N_DIGITS, 4, number of digits scanned; legal range 1..8
- REFRESH_DIV, 50000, clock cycles each digit is held; legal range ≥ 2
- i_clk  input  1  system clock; single clock domain
- i_reset  input  1  synchronous, active-high reset
- i_data  input  4*N_DIGITS  hex nibble per digit; digit k = i_data[4k+3:4k]; digit 0 is rightmost/least significant
- i_dp  input  N_DIGITS  decimal point request per digit, active-high
- i_blank_lz  input  1  1 = blank leading zeros
- i_enable  input  1  0 = all anodes off; counters keep running
- o_segments  output  7  active-low segments, order abc_defg (bit 6 = a, bit 0 = g)
- o_dp  output  1  active-low decimal point
- o_anodes  output  N_DIGITS  active-low digit select; at most one bit low
- o_frame  output  1  one-cycle pulse when a new frame's data is captured

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt == REFRESH_DIV-1).
- Digit index idx advances on tick, modulo N_DIGITS: N_DIGITS-1 → 0.
- Shadow registers sh_data and sh_dp capture i_data and i_dp on a tick with idx == N_DIGITS-1, i.e. the frame boundary. Inputs are ignored at all other times.
- Leading-zero blanking applies when i_blank_lz = 1:
  - Digit k is blank if every shadow nibble at positions k..N_DIGITS-1 is 0.
  - Digit 0 is never blanked.
  - A blanked digit still shows its dp if its sh_dp bit is set.
- Decode (active-low abc_defg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - blank=1111111
- Dead time: during the cycle where cnt == 0, all anodes are off (all ones).
- i_blank_lz is sampled live, not shadowed.
- i_enable is sampled live. When low, o_anodes is all ones, and segments and dp still follow idx.

## Timing
- All outputs are registered. Each output reflects cnt, idx, sh_* and the live inputs from the previous cycle, giving 1-cycle latency.
- Reset values:
  - cnt = 0, idx = 0, sh_data = 0, sh_dp = 0
  - o_anodes = all ones, o_segments = 1111111, o_dp = 1, o_frame = 0
- Digit slot length is REFRESH_DIV cycles: 1 dead cycle followed by REFRESH_DIV-1 lit cycles.
- Frame period is N_DIGITS × REFRESH_DIV cycles.
- The first capture occurs N_DIGITS × REFRESH_DIV cycles after reset deasserts.
- o_frame goes high in the cycle after the capturing tick, for exactly 1 cycle.
- Input change in the same cycle as the capturing tick: the new value is captured.
- N_DIGITS = 1: idx stays 0, and a capture occurs on every tick.
- Reset asserted mid-scan: all state returns to reset values on the next edge. No partial frame is completed.
- cnt width = $clog2(REFRESH_DIV). idx width = max(1, $clog2(N_DIGITS)).

## Structure
- Package sevenseg_pkg holds:
  - SEG_BLANK constant and the 16-entry hex segment table constant
  - function hex_to_seg(logic [3:0]) → logic [6:0]
- Sub-module sevenseg_lzb: combinational leading-zero mask, N_DIGITS nibbles in → N_DIGITS blank flags out.
- Top holds the prescaler, idx counter, shadow registers and output registers.

## Test plan
- Reset release with N_DIGITS=4, REFRESH_DIV=4:
  - o_anodes=1111 during reset and during the dead cycles.
  - First lit slot shows o_anodes=1110 with o_segments=0000001.
- i_data=16'h12AF, i_dp=4'b0100, i_blank_lz=0:
  - After the first o_frame, the scan shows F (0111000), A (0001000), 2 (0010010), 1 (1001111) on anodes 1110, 1101, 1011, 0111.
  - o_dp is low only on anode 1011.
- i_data=16'h0070, i_blank_lz=1:
  - Digits 3 and 2 show 1111111.
  - Digit 1 shows 7 (0001111), digit 0 shows 0 (0000001).
  - i_data=0 leaves only digit 0 lit, showing 0.
- Change i_data mid-frame:
  - Displayed value changes only after the next o_frame pulse.
  - Frame period is exactly 16 cycles.
- i_enable=0 for a full frame: o_anodes stays all ones, and o_frame still pulses.
- Assert i_reset while idx=2: outputs return to reset values, and the next capture is 16 cycles after deassert.
